// File: rtl/mul_seq_ctrl.sv
// Sequencer for the shift-add multiplier: LOAD, then N add/shift steps, then a one-cycle DONE.
// Optional early termination on an all-zero remaining multiplier via MUL_EARLY_TERM_EN.
module mul_seq_ctrl #(
   parameter int N     = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_start,
   input  logic             op_clear,
   input  logic             mplr_zero,
   output logic             load_en,
   output logic             acc_clr,
   output logic             step_en,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_EXEC,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

`ifndef MUL_EARLY_TERM_EN
   logic unused_mplr_zero;
   assign unused_mplr_zero = mplr_zero;
`endif

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      load_en = 1'b0;
      step_en = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (op_start && !op_clear) state_d = S_LOAD;
         end
         S_LOAD: begin
            load_en = 1'b1;
            busy    = 1'b1;
            count_d = '0;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            busy = 1'b1;
`ifdef MUL_EARLY_TERM_EN
            // No set bits left: skip the remaining steps, count keeps the steps done.
            if (mplr_zero) begin
               state_d = S_DONE;
            end else begin
               step_en = 1'b1;
               count_d = count_q + CNT_W'(1);
               if (count_q == LAST_STEP) state_d = S_DONE;
            end
`else
            step_en = 1'b1;
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST_STEP) state_d = S_DONE;
`endif
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Abort discards the op; in IDLE it only clears the accumulator.
      if (op_clear && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         count_d = '0;
      end
   end

   assign acc_clr = (state_q == S_LOAD) | op_clear;
   assign count   = count_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: per-cycle stimulus and expected outputs are queued, then replayed.
module tb_mul_seq_ctrl;
   localparam int N  = 32;
   localparam int CW = 6;

   typedef logic [CW+4:0] vec_t; // {load_en, acc_clr, step_en, busy, done, count}
   typedef struct packed {
      logic st;
      logic clr;
      logic mz;
      vec_t exp;
   } ent_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          op_start = 1'b1;
   logic          op_clear = 1'b0;
   logic          mplr_zero = 1'b0;
   logic          load_en, acc_clr, step_en, busy, done;
   logic [CW-1:0] count;

   int   tests = 0;
   int   fails = 0;
   ent_t sb[$];

   mul_seq_ctrl #(.N(N), .CNT_W(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .op_start  (op_start),
      .op_clear  (op_clear),
      .mplr_zero (mplr_zero),
      .load_en   (load_en),
      .acc_clr   (acc_clr),
      .step_en   (step_en),
      .count     (count),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   function automatic vec_t ev(logic l, logic a, logic s, logic b, logic d, int c);
      return {l, a, s, b, d, CW'(c)};
   endfunction

   function automatic void push(logic st, logic clr, logic mz, vec_t e);
      ent_t x;
      x.st  = st;
      x.clr = clr;
      x.mz  = mz;
      x.exp = e;
      sb.push_back(x);
   endfunction

   // Drive inputs for one cycle and sample outputs (including combinational acc_clr).
   task automatic drive(input logic rst, input logic st, input logic clr, input logic mz,
                        output vec_t act);
      @(negedge clk);
      reset     = rst;
      op_start  = st;
      op_clear  = clr;
      mplr_zero = mz;
      #1;
      act = {load_en, acc_clr, step_en, busy, done, count};
   endtask

   task automatic test_reset();
      vec_t act;
      drive(1'b1, 1'b1, 1'b0, 1'b0, act);
      drive(1'b1, 1'b1, 1'b0, 1'b0, act);
      tests++;
      if (act !== ev(0, 0, 0, 0, 0, 0)) begin
         fails++;
         $display("FAIL reset_held: got %h expected %h", act, ev(0, 0, 0, 0, 0, 0));
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, act);
      drive(1'b0, 1'b0, 1'b0, 1'b0, act);
      tests++;
      if (act !== ev(0, 0, 0, 0, 0, 0)) begin
         fails++;
         $display("FAIL reset_released: got %h expected %h", act, ev(0, 0, 0, 0, 0, 0));
      end
   endtask

   task automatic test_full_op(input int prev);
      vec_t act;
      ent_t e;
      int   idx = 0;
      push(1, 0, 0, ev(0, 0, 0, 0, 0, prev));
      push(0, 0, 0, ev(1, 1, 0, 1, 0, prev));
      for (int i = 0; i < N; i++) push(0, 0, 0, ev(0, 0, 1, 1, 0, i));
      push(0, 0, 0, ev(0, 0, 0, 0, 1, N));
      push(0, 0, 0, ev(0, 0, 0, 0, 0, N));
      push(0, 0, 0, ev(0, 0, 0, 0, 0, N));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         drive(1'b0, e.st, e.clr, e.mz, act);
         tests++;
         if (act !== e.exp) begin
            fails++;
            $display("FAIL full_op[%0d]: got %h expected %h", idx, act, e.exp);
         end
         idx++;
      end
   endtask

   task automatic test_clear(input int prev);
      vec_t act;
      ent_t e;
      int   idx = 0;
      push(1, 0, 0, ev(0, 0, 0, 0, 0, prev));
      push(0, 0, 0, ev(1, 1, 0, 1, 0, prev));
      for (int i = 0; i < 10; i++) push(0, 0, 0, ev(0, 0, 1, 1, 0, i));
      push(0, 1, 0, ev(0, 1, 1, 1, 0, 10));
      for (int i = 0; i < N + 4; i++) push(0, 0, 0, ev(0, 0, 0, 0, 0, 0));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         drive(1'b0, e.st, e.clr, e.mz, act);
         tests++;
         if (act !== e.exp) begin
            fails++;
            $display("FAIL clear[%0d]: got %h expected %h", idx, act, e.exp);
         end
         idx++;
      end
   endtask

   task automatic test_start_clear_same(input int prev);
      vec_t act;
      ent_t e;
      int   idx = 0;
      push(0, 1, 0, ev(0, 1, 0, 0, 0, prev));
      push(1, 1, 0, ev(0, 1, 0, 0, 0, prev));
      push(0, 0, 0, ev(0, 0, 0, 0, 0, prev));
      push(0, 0, 0, ev(0, 0, 0, 0, 0, prev));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         drive(1'b0, e.st, e.clr, e.mz, act);
         tests++;
         if (act !== e.exp) begin
            fails++;
            $display("FAIL start_clear[%0d]: got %h expected %h", idx, act, e.exp);
         end
         idx++;
      end
   endtask

   // op_start stays high through the first op and the following IDLE cycle.
   task automatic test_back_to_back(input int prev);
      vec_t act;
      ent_t e;
      int   idx = 0;
      push(1, 0, 0, ev(0, 0, 0, 0, 0, prev));
      push(1, 0, 0, ev(1, 1, 0, 1, 0, prev));
      for (int i = 0; i < N; i++) push(1, 0, 0, ev(0, 0, 1, 1, 0, i));
      push(1, 0, 0, ev(0, 0, 0, 0, 1, N));
      push(1, 0, 0, ev(0, 0, 0, 0, 0, N));
      push(0, 0, 0, ev(1, 1, 0, 1, 0, N));
      for (int i = 0; i < N; i++) push(0, 0, 0, ev(0, 0, 1, 1, 0, i));
      push(0, 0, 0, ev(0, 0, 0, 0, 1, N));
      for (int i = 0; i < 4; i++) push(0, 0, 0, ev(0, 0, 0, 0, 0, N));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         drive(1'b0, e.st, e.clr, e.mz, act);
         tests++;
         if (act !== e.exp) begin
            fails++;
            $display("FAIL back_to_back[%0d]: got %h expected %h", idx, act, e.exp);
         end
         idx++;
      end
   endtask

   // mplr_zero rises in the 5th EXEC cycle and stays high.
   task automatic test_early_term(input int prev);
      vec_t act;
      ent_t e;
      int   idx = 0;
      push(1, 0, 0, ev(0, 0, 0, 0, 0, prev));
      push(0, 0, 0, ev(1, 1, 0, 1, 0, prev));
      for (int i = 0; i < 4; i++) push(0, 0, 0, ev(0, 0, 1, 1, 0, i));
`ifdef MUL_EARLY_TERM_EN
      push(0, 0, 1, ev(0, 0, 0, 1, 0, 4));
      push(0, 0, 1, ev(0, 0, 0, 0, 1, 4));
      push(0, 0, 1, ev(0, 0, 0, 0, 0, 4));
      push(0, 0, 0, ev(0, 0, 0, 0, 0, 4));
`else
      for (int i = 4; i < N; i++) push(0, 0, 1, ev(0, 0, 1, 1, 0, i));
      push(0, 0, 1, ev(0, 0, 0, 0, 1, N));
      push(0, 0, 1, ev(0, 0, 0, 0, 0, N));
      push(0, 0, 0, ev(0, 0, 0, 0, 0, N));
`endif
      while (sb.size() > 0) begin
         e = sb.pop_front();
         drive(1'b0, e.st, e.clr, e.mz, act);
         tests++;
         if (act !== e.exp) begin
            fails++;
            $display("FAIL early_term[%0d]: got %h expected %h", idx, act, e.exp);
         end
         idx++;
      end
   endtask

   initial begin
      test_reset();
      test_full_op(0);
      test_clear(N);
      test_start_clear_same(0);
      test_back_to_back(0);
      test_early_term(N);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
